// File: rtl/ctr_main_if.sv
// ---------------------------------------------------------------------------
// ctr_main_if
// Interface between the instruction-fetch side and the main control
// decoder. The master drives the opcode; the slave (ctr_main) returns the
// registered datapath control strobes.
//   opCode    6  instruction bits [31:26]
//   regDst    1  1 = write-register is rd, 0 = rt
//   jump      1  PC takes the jump target
//   branchEq  1  beq, taken when the ALU result is zero
//   branchNeq 1  bne, taken when the ALU result is nonzero
//   memRead   1  data-memory read enable
//   memtoReg  1  1 = write-back from memory, 0 = from ALU
//   memWrite  1  data-memory write enable
//   aluSrc    1  1 = ALU operand B is the sign-extended immediate
//   regWrite  1  register-file write enable
//   aluOp     2  00 add, 01 sub, 10 funct field, 11 and
// ---------------------------------------------------------------------------
interface ctr_main_if;
  logic [5:0] opCode;
  logic       regDst;
  logic       jump;
  logic       branchEq;
  logic       branchNeq;
  logic       memRead;
  logic       memtoReg;
  logic       memWrite;
  logic       aluSrc;
  logic       regWrite;
  logic [1:0] aluOp;

  modport master (
    output opCode,
    input  regDst, jump, branchEq, branchNeq, memRead, memtoReg,
           memWrite, aluSrc, regWrite, aluOp
  );

  modport slave (
    input  opCode,
    output regDst, jump, branchEq, branchNeq, memRead, memtoReg,
           memWrite, aluSrc, regWrite, aluOp
  );
endinterface

// File: rtl/ctr_main.sv
// ---------------------------------------------------------------------------
// ctr_main
// Main control decoder of the MIPS-subset single-cycle datapath. Decodes
// the 6-bit opcode into control strobes and a 2-bit ALU-op class; the
// result is registered (1-cycle latency) so downstream logic sees
// glitch-free, reset-safe controls.
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears every output (a NOP)
//   bus    ctr_main_if.slave: opCode in, control strobes out
// ---------------------------------------------------------------------------
module ctr_main (
  input  logic        clk,
  input  logic        reset,
  ctr_main_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Packed control word, MSB first:
  // {regDst,jump,branchEq,branchNeq,memRead,memtoReg,memWrite,aluSrc,regWrite,aluOp[1:0]}
  logic [10:0] ctrl_d;
  logic [10:0] ctrl_q;

  // Unlisted opcodes, and X/Z opcodes (which match no item), fall to the
  // all-zero NOP word, so outputs never carry X.
  always_comb begin
    ctrl_d = '0;
    case (bus.opCode)
      OP_RTYPE: ctrl_d = 11'b1_0_0_0_0_0_0_0_1_10;
      OP_LW:    ctrl_d = 11'b0_0_0_0_1_1_0_1_1_00;
      OP_SW:    ctrl_d = 11'b0_0_0_0_0_0_1_1_0_00;
      OP_BEQ:   ctrl_d = 11'b0_0_1_0_0_0_0_0_0_01;
      OP_BNE:   ctrl_d = 11'b0_0_0_1_0_0_0_0_0_01;
      OP_ADDI:  ctrl_d = 11'b0_0_0_0_0_0_0_1_1_00;
      OP_ANDI:  ctrl_d = 11'b0_0_0_0_0_0_0_1_1_11;
      OP_J:     ctrl_d = 11'b0_1_0_0_0_0_0_0_0_00;
      default:  ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.regDst    = ctrl_q[10];
  assign bus.jump      = ctrl_q[9];
  assign bus.branchEq  = ctrl_q[8];
  assign bus.branchNeq = ctrl_q[7];
  assign bus.memRead   = ctrl_q[6];
  assign bus.memtoReg  = ctrl_q[5];
  assign bus.memWrite  = ctrl_q[4];
  assign bus.aluSrc    = ctrl_q[3];
  assign bus.regWrite  = ctrl_q[2];
  assign bus.aluOp     = ctrl_q[1:0];

endmodule

// File: tb/tb_ctr_main.sv
// ---------------------------------------------------------------------------
// tb_ctr_main
// Scoreboard bench for ctr_main: each opcode driven pushes its expected
// control word; the word is popped and compared one edge later.
// ---------------------------------------------------------------------------
module tb_ctr_main;

  logic clk;
  logic reset;
  ctr_main_if bus ();

  ctr_main dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {bus.regDst, bus.jump, bus.branchEq, bus.branchNeq, bus.memRead,
                bus.memtoReg, bus.memWrite, bus.aluSrc, bus.regWrite, bus.aluOp};

  int checks   = 0;
  int failures = 0;
  logic [10:0] sb_q[$];
  logic [10:0] last_exp;

  task automatic check_vec(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Reference decode, written from the opcode table.
  function automatic logic [10:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return 11'b10000000110;
      6'b100011: return 11'b00001101100;
      6'b101011: return 11'b00000011000;
      6'b000100: return 11'b00100000001;
      6'b000101: return 11'b00010000001;
      6'b001000: return 11'b00000001100;
      6'b001100: return 11'b00000001111;
      6'b000010: return 11'b01000000000;
      default:   return 11'b00000000000;
    endcase
  endfunction

  // Drive at the falling edge, compare 1 time unit after the next rising edge.
  task automatic apply(input string tag, input logic [5:0] op, input logic [10:0] exp);
    logic [10:0] e;
    @(negedge clk);
    bus.opCode = op;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_vec({tag, "_sb_empty"}, obs, 11'bx);
    end else begin
      e = sb_q.pop_front();
      check_vec(tag, obs, e);
      last_exp = e;
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [10:0] exp;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset      = 1'b0;
    bus.opCode = 6'b000000;
    last_exp   = '0;

    // Asynchronous reset, before any clock edge.
    #2 reset = 1'b1;
    #1 check_vec("reset_async", obs, 11'b0);
    @(posedge clk);
    #1 check_vec("reset_hold", obs, 11'b0);

    @(negedge clk);
    reset = 1'b0;

    tbl.push_back('{6'b000000, 11'b1_0_0_0_0_0_0_0_1_10, "rtype"});
    tbl.push_back('{6'b000100, 11'b0_0_1_0_0_0_0_0_0_01, "beq"});
    tbl.push_back('{6'b000101, 11'b0_0_0_1_0_0_0_0_0_01, "bne"});
    tbl.push_back('{6'b101011, 11'b0_0_0_0_0_0_1_1_0_00, "sw"});
    tbl.push_back('{6'b100011, 11'b0_0_0_0_1_1_0_1_1_00, "lw"});
    tbl.push_back('{6'b001000, 11'b0_0_0_0_0_0_0_1_1_00, "addi"});
    tbl.push_back('{6'b001100, 11'b0_0_0_0_0_0_0_1_1_11, "andi"});
    tbl.push_back('{6'b000010, 11'b0_1_0_0_0_0_0_0_0_00, "j"});
    foreach (tbl[i]) apply(tbl[i].tag, tbl[i].op, tbl[i].exp);

    // Latency: change opCode between edges, outputs must hold.
    @(negedge clk);
    bus.opCode = 6'b100011;
    #1 check_vec("latency_hold", obs, last_exp);

    // Undefined opcode.
    apply("undef_3f", 6'b111111, 11'b0);

    // Random opcodes against the reference decode.
    for (int i = 0; i < 24; i++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 63));
      apply($sformatf("rand_%02h", op), op, ref_decode(op));
    end

    // Reset mid-cycle after lw: outputs drop at once.
    apply("lw_pre_reset", 6'b100011, 11'b0_0_0_0_1_1_0_1_1_00);
    #2 reset = 1'b1;
    #1 check_vec("reset_midcycle", obs, 11'b0);
    @(negedge clk);
    reset = 1'b0;
    apply("rtype_post_reset", 6'b000000, 11'b1_0_0_0_0_0_0_0_1_10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
